// File: rtl/vs_dc_ascii_hex.sv
// Registered ASCII-to-hex-digit decoder for the UART receive path.
// Each cycle's ASCII sample becomes a nibble plus a valid-digit flag one clock later.
module vs_dc_ascii_hex #(
  parameter bit LOWER_CASE_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [7:0] ASCII,
  output logic [3:0] HEX,
  output logic       HEX_FLG
);

  logic [3:0] dec_hex;
  logic       dec_flg;

  // Full 8-bit range compares so that bit-7 aliases such as 0xB0 stay invalid.
  // For 'A'..'F' and 'a'..'f' the low nibble is 1..6, so adding 9 yields 10..15.
  always_comb begin
    dec_hex = '0;
    dec_flg = 1'b0;
    if (ASCII >= 8'h30 && ASCII <= 8'h39) begin
      dec_hex = ASCII[3:0];
      dec_flg = 1'b1;
    end else if (ASCII >= 8'h41 && ASCII <= 8'h46) begin
      dec_hex = ASCII[3:0] + 4'd9;
      dec_flg = 1'b1;
    end else if (LOWER_CASE_EN && ASCII >= 8'h61 && ASCII <= 8'h66) begin
      dec_hex = ASCII[3:0] + 4'd9;
      dec_flg = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      HEX     <= '0;
      HEX_FLG <= 1'b0;
    end else begin
      HEX     <= dec_hex;
      HEX_FLG <= dec_flg;
    end
  end

endmodule

// File: tb/tb_vs_dc_ascii_hex.sv
// Bench for vs_dc_ascii_hex: one instance with lower case accepted, one upper case only,
// both fed the same ASCII stream and checked against a queued reference decode.
module tb_vs_dc_ascii_hex;

  logic       CLK;
  logic       RST_n;
  logic [7:0] ASCII;
  logic [3:0] hex_lc, hex_uc;
  logic       flg_lc, flg_uc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [4:0] q_lc[$];
  logic [4:0] q_uc[$];

  vs_dc_ascii_hex #(.LOWER_CASE_EN(1'b1)) u_dut_lc (
    .CLK(CLK), .RST_n(RST_n), .ASCII(ASCII), .HEX(hex_lc), .HEX_FLG(flg_lc)
  );

  vs_dc_ascii_hex #(.LOWER_CASE_EN(1'b0)) u_dut_uc (
    .CLK(CLK), .RST_n(RST_n), .ASCII(ASCII), .HEX(hex_uc), .HEX_FLG(flg_uc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: search the digit character table; returns {flag, nibble}.
  function automatic logic [4:0] ref_decode(input logic [7:0] a, input bit lc);
    logic [7:0] up, lo;
    ref_decode = 5'h00;
    for (int i = 0; i < 16; i++) begin
      up = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
      lo = 8'(8'h61 + i - 10);
      if (a == up || (lc && i >= 10 && a == lo))
        ref_decode = {1'b1, 4'(i)};
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] e_lc, e_uc;
    if (q_lc.size() == 0 || q_uc.size() == 0) begin
      check({tag, "_qempty"}, 8'd1, 8'd0);
    end else begin
      e_lc = q_lc.pop_front();
      e_uc = q_uc.pop_front();
      check({tag, "_lc"}, {3'b0, flg_lc, hex_lc}, {3'b0, e_lc});
      check({tag, "_uc"}, {3'b0, flg_uc, hex_uc}, {3'b0, e_uc});
    end
  endtask

  // Drive one code, expect its decode after the next rising edge.
  task automatic step(input logic [7:0] a, input string tag);
    ASCII = a;
    q_lc.push_back(ref_decode(a, 1'b1));
    q_uc.push_back(ref_decode(a, 1'b0));
    @(posedge CLK);
    #1;
    check_outputs($sformatf("%s_%02h", tag, a));
  endtask

  task automatic expect_cleared(input string tag);
    check({tag, "_lc"}, {3'b0, flg_lc, hex_lc}, 8'h00);
    check({tag, "_uc"}, {3'b0, flg_uc, hex_uc}, 8'h00);
  endtask

  logic [7:0] bad_codes[9] = '{8'h00, 8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67, 8'hB5, 8'hFF};

  initial begin
    RST_n = 1'b0;
    ASCII = 8'h41;

    // Reset held with a valid digit on the input.
    repeat (4) begin
      @(posedge CLK);
      #1;
      expect_cleared("rst_hold");
    end
    RST_n = 1'b1;
    step(8'h41, "rst_rel");

    for (int unsigned c = 8'h30; c <= 8'h39; c++) step(8'(c), "digit");

    for (int unsigned i = 0; i < 6; i++) begin
      step(8'(8'h41 + i), "upper");
      step(8'(8'h61 + i), "lower");
    end

    foreach (bad_codes[i]) step(bad_codes[i], "bad");

    // Latency / stale value, plus a mid-cycle glitch that must not reach the outputs.
    step(8'h39, "lat");
    #3;
    ASCII = 8'h30;
    #1;
    check("glitch_lc", {3'b0, flg_lc, hex_lc}, 8'h19);
    check("glitch_uc", {3'b0, flg_uc, hex_uc}, 8'h19);
    step(8'h47, "lat");

    // Asynchronous reset between edges while F is flagged.
    step(8'h46, "pre_arst");
    #3;
    RST_n = 1'b0;
    #1;
    expect_cleared("arst");
    ASCII = 8'h37;
    #1;
    RST_n = 1'b1;
    step(8'h37, "post_arst");

    for (int unsigned c = 0; c < 256; c++) step(8'(c), "sweep");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
